// File: rtl/filter_mode_ctrl.sv
// Filter mode controller: frame-aligned mode switching
// with sync edge detection and pixel/line/frame counters.
module filter_mode_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 6,
  parameter logic [1:0]  MODE_RST      = 2'b00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       H_sync,
  input  logic       V_sync,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  input  logic       btn_next,
  output logic [1:0] Filter_en,
  output logic       pending,
  output logic       switching,
  output logic       sof,
  output logic [9:0] pix_cnt,
  output logic [9:0] line_cnt,
  output logic [7:0] frame_cnt
);

  localparam int CW =
    (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     pend_mode, pend_nxt;
  logic [1:0]     mode_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           req_flag, flag_nxt;
  logic           hs_q, vs_q;
  logic           h_rise, v_rise;

  assign h_rise = H_sync & ~hs_q;
  assign v_rise = V_sync & ~vs_q;

  // Next-state, pending-mode and settle-counter logic
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_mode;
    mode_nxt  = Filter_en;
    cnt_nxt   = cnt;
    flag_nxt  = 1'b0;
    case (state)
      ACTIVE: begin
        if (mode_req_valid) begin
          if (mode_req != Filter_en) begin
            pend_nxt  = mode_req;
            state_nxt = PENDING;
          end
        end else if (btn_next) begin
          pend_nxt  = Filter_en + 2'd1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (mode_req_valid)
          pend_nxt = mode_req;
        else if (btn_next)
          pend_nxt = pend_mode + 2'd1;
        if (v_rise) begin
          mode_nxt  = pend_nxt;
          cnt_nxt   = CW'(SETTLE_CYCLES);
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        flag_nxt = req_flag;
        if (mode_req_valid) begin
          pend_nxt = mode_req;
          flag_nxt = 1'b1;
        end else if (btn_next) begin
          pend_nxt = pend_mode + 2'd1;
          flag_nxt = 1'b1;
        end
        if (cnt != '0)
          cnt_nxt = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_nxt = flag_nxt ? PENDING : ACTIVE;
          flag_nxt  = 1'b0;
        end
      end
      default: state_nxt = ACTIVE;
    endcase
  end

  // Mode FSM registers and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ACTIVE;
      pend_mode <= MODE_RST;
      Filter_en <= MODE_RST;
      cnt       <= '0;
      req_flag  <= 1'b0;
      pending   <= 1'b0;
      switching <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_mode <= pend_nxt;
      Filter_en <= mode_nxt;
      cnt       <= cnt_nxt;
      req_flag  <= flag_nxt;
      pending   <= (state_nxt == PENDING);
      switching <= (state_nxt == SETTLE);
    end
  end

  // Sync edge capture, start-of-frame pulse and position counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      sof       <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      hs_q <= H_sync;
      vs_q <= V_sync;
      sof  <= v_rise;
      if (h_rise)
        pix_cnt <= '0;
      else if (EN && pix_cnt != 10'h3FF)
        pix_cnt <= pix_cnt + 10'd1;
      if (v_rise)
        line_cnt <= '0;
      else if (h_rise && line_cnt != 10'h3FF)
        line_cnt <= line_cnt + 10'd1;
      if (v_rise)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Directed self-checking bench for filter_mode_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_filter_mode_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       H_sync;
  logic       V_sync;
  logic [1:0] mode_req;
  logic       mode_req_valid;
  logic       btn_next;
  logic [1:0] Filter_en;
  logic       pending;
  logic       switching;
  logic       sof;
  logic [9:0] pix_cnt;
  logic [9:0] line_cnt;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int n;
  int k;

  filter_mode_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .H_sync(H_sync),
    .V_sync(V_sync),
    .mode_req(mode_req),
    .mode_req_valid(mode_req_valid),
    .btn_next(btn_next),
    .Filter_en(Filter_en),
    .pending(pending),
    .switching(switching),
    .sof(sof),
    .pix_cnt(pix_cnt),
    .line_cnt(line_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle_len(output int len);
    len = 0;
    while (switching && len < 20) begin
      len++;
      step();
    end
  endtask

  task automatic vpulse();
    V_sync = 1'b1;
    step();
    V_sync = 1'b0;
    step();
  endtask

  initial begin
    RST = 1'b1;
    EN = 1'b0;
    H_sync = 1'b0;
    V_sync = 1'b0;
    mode_req = 2'b00;
    mode_req_valid = 1'b0;
    btn_next = 1'b0;
    step();
    step();
    chk("rst_fen", Filter_en, 0);
    chk("rst_pend", pending, 0);
    chk("rst_sw", switching, 0);
    chk("rst_sof", sof, 0);
    chk("rst_pix", pix_cnt, 0);
    chk("rst_line", line_cnt, 0);
    chk("rst_frame", frame_cnt, 0);
    RST = 1'b0;
    step();

    // basic request, applied at the next frame
    mode_req = 2'b01;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    chk("pend_latency", pending, 1);
    n = 1;
    repeat (19) begin
      step();
      if (pending) n++;
    end
    chk("pend_clocks", n, 20);
    chk("fen_hold", Filter_en, 0);
    V_sync = 1'b1;
    step();
    V_sync = 1'b0;
    chk("apply_sof", sof, 1);
    chk("apply_fen", Filter_en, 1);
    chk("apply_sw", switching, 1);
    chk("apply_pend", pending, 0);
    chk("apply_frame", frame_cnt, 1);
    step();
    chk("sof_one", sof, 0);
    settle_len(n);
    chk("settle_len", n + 1, 6);
    chk("active_sw", switching, 0);
    chk("active_pend", pending, 0);

    // reach mode 11, then two btn_next presses
    mode_req = 2'b11;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    vpulse();
    repeat (6) step();
    chk("fen_11", Filter_en, 3);
    chk("fen_11_sw", switching, 0);
    btn_next = 1'b1;
    step();
    chk("btn_pend", pending, 1);
    step();
    btn_next = 1'b0;
    chk("btn_hold", Filter_en, 3);
    V_sync = 1'b1;
    step();
    V_sync = 1'b0;
    chk("btn_twice", Filter_en, 1);
    repeat (6) step();

    // back to 00, then valid+btn together
    mode_req = 2'b00;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    vpulse();
    repeat (6) step();
    chk("fen_00", Filter_en, 0);
    mode_req = 2'b10;
    mode_req_valid = 1'b1;
    btn_next = 1'b1;
    step();
    mode_req_valid = 1'b0;
    btn_next = 1'b0;
    V_sync = 1'b1;
    step();
    V_sync = 1'b0;
    chk("valid_prio", Filter_en, 2);
    repeat (6) step();
    chk("settled_10", switching, 0);

    // same-mode request is ignored
    mode_req = 2'b10;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    chk("same_ignored", pending, 0);

    // request during SETTLE
    mode_req = 2'b01;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    V_sync = 1'b1;
    step();
    V_sync = 1'b0;
    chk("fen_01", Filter_en, 1);
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    settle_len(n);
    chk("settle_req_len", n, 5);
    chk("settle_to_pend", pending, 1);
    chk("settle_fen_hold", Filter_en, 1);
    V_sync = 1'b1;
    step();
    V_sync = 1'b0;
    chk("settle_req_apply", Filter_en, 2);
    repeat (6) step();

    // request coincident with V_sync rise in PENDING
    mode_req = 2'b11;
    mode_req_valid = 1'b1;
    step();
    mode_req = 2'b00;
    V_sync = 1'b1;
    step();
    mode_req_valid = 1'b0;
    V_sync = 1'b0;
    chk("coincident_req", Filter_en, 0);
    repeat (6) step();

    // pixel / line / frame counters
    V_sync = 1'b1;
    H_sync = 1'b1;
    step();
    V_sync = 1'b0;
    H_sync = 1'b0;
    step();
    for (int l = 0; l < 3; l++) begin
      H_sync = 1'b1;
      step();
      H_sync = 1'b0;
      chk("line_start_pix", pix_cnt, 0);
      EN = 1'b1;
      repeat (640) step();
      EN = 1'b0;
      step();
      chk("pix_peak", pix_cnt, 640);
    end
    chk("line_3", line_cnt, 3);
    k = frame_cnt;
    V_sync = 1'b1;
    H_sync = 1'b1;
    step();
    V_sync = 1'b0;
    H_sync = 1'b0;
    chk("frame_sof", sof, 1);
    chk("frame_line_clr", line_cnt, 0);
    chk("frame_pix_clr", pix_cnt, 0);
    chk("frame_inc", frame_cnt, (k + 1) % 256);
    step();
    EN = 1'b1;
    repeat (1100) step();
    EN = 1'b0;
    chk("pix_sat", pix_cnt, 1023);
    repeat (1030) begin
      H_sync = 1'b1;
      step();
      H_sync = 1'b0;
      step();
    end
    chk("line_sat", line_cnt, 1023);
    n = 0;
    while (frame_cnt != 8'd255 && n < 300) begin
      vpulse();
      n++;
    end
    chk("frame_255", frame_cnt, 255);
    vpulse();
    chk("frame_wrap", frame_cnt, 0);

    // reset while PENDING(10), with V_sync held high
    mode_req = 2'b10;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    chk("pend_10", pending, 1);
    RST = 1'b1;
    V_sync = 1'b1;
    step();
    chk("rst_pend_clr", pending, 0);
    chk("rst_fen_clr", Filter_en, 0);
    chk("rst_frame_clr", frame_cnt, 0);
    RST = 1'b0;
    step();
    chk("rst_sync_edge", sof, 1);
    chk("rst_edge_frame", frame_cnt, 1);
    chk("rst_no_switch", switching, 0);
    V_sync = 1'b0;
    step();
    vpulse();
    chk("rst_discard_fen", Filter_en, 0);
    chk("rst_discard_sw", switching, 0);
    chk("rst_discard_pend", pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
